// File: rtl/fpu_divsqrt_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_divsqrt_scheduler_pkg
// Purpose  : Shared types and constants for the divide/sqrt scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_divsqrt_scheduler_pkg;

  localparam int FDIVSQRT_ITER_CYCLES      = 14;
  // Storage bounds for the latched request; TAG_WIDTH must not exceed 16.
  localparam int FDIVSQRT_MAX_TAG_WIDTH    = 16;
  localparam int FDIVSQRT_MAX_THREAD_WIDTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } FDivSqrtSchedState;

  typedef struct packed {
    logic                                 is_divide;
    logic [31:0]                          lhs;
    logic [31:0]                          rhs;
    logic [FDIVSQRT_MAX_TAG_WIDTH-1:0]    tag;
    logic [FDIVSQRT_MAX_THREAD_WIDTH-1:0] thread;
  } FDivSqrtSchedReq;

endpackage
`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_rr_arbiter
// Purpose  : Round-robin grant starting the search at a supplied pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_rr_arbiter #(
  parameter int NUM_THREADS = 2
) (
  input  logic [NUM_THREADS-1:0]         req_i,
  input  logic [$clog2(NUM_THREADS)-1:0] ptr_i,
  output logic [NUM_THREADS-1:0]         grant_o,
  output logic [$clog2(NUM_THREADS)-1:0] grant_idx_o,
  output logic                           grant_valid_o
);

  localparam int TW = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0] rot;
  logic [TW:0]            sum;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    sum           = '0;
    // rot[k] holds the request of thread (ptr + k) mod NUM_THREADS
    rot = NUM_THREADS'({req_i, req_i} >> ptr_i);
    for (int k = 0; k < NUM_THREADS; k++) begin
      if (!grant_valid_o && rot[k]) begin
        grant_valid_o = 1'b1;
        sum = {1'b0, ptr_i} + (TW+1)'(k);
        if (sum >= (TW+1)'(NUM_THREADS)) begin
          sum = sum - (TW+1)'(NUM_THREADS);
        end
        grant_idx_o = sum[TW-1:0];
      end
    end
    if (grant_valid_o) begin
      grant_o = NUM_THREADS'(1) << grant_idx_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_divsqrt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fpu_divsqrt_scheduler
// Purpose  : Shares one iterative div/sqrt unit between SMT threads.
//            FPU_DIVSQRT_SCHED_STATS_EN adds busy/conflict cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_divsqrt_scheduler
  import fpu_divsqrt_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int TAG_WIDTH   = 7,
  parameter int ITER_CYCLES = FDIVSQRT_ITER_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_THREADS-1:0]                req_valid,
  output logic [NUM_THREADS-1:0]                req_ready,
  input  logic [NUM_THREADS-1:0]                req_is_divide,
  input  logic [NUM_THREADS-1:0][31:0]          req_lhs,
  input  logic [NUM_THREADS-1:0][31:0]          req_rhs,
  input  logic [NUM_THREADS-1:0][TAG_WIDTH-1:0] req_tag,
  input  logic [NUM_THREADS-1:0]                flush,
  output logic                                  unit_start,
  output logic                                  unit_kill,
  output logic                                  unit_is_divide,
  output logic [31:0]                           unit_lhs,
  output logic [31:0]                           unit_rhs,
  input  logic [31:0]                           unit_result,
  input  logic [4:0]                            unit_fflags,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [$clog2(NUM_THREADS)-1:0]        resp_thread,
  output logic [TAG_WIDTH-1:0]                  resp_tag,
  output logic [31:0]                           resp_data,
  output logic [4:0]                            resp_fflags
`ifdef FPU_DIVSQRT_SCHED_STATS_EN
  ,
  output logic [31:0]                           stat_busy_cycles,
  output logic [31:0]                           stat_conflict_cycles
`endif
);

  localparam int TW = $clog2(NUM_THREADS);
  localparam int CW = $clog2(ITER_CYCLES);

  FDivSqrtSchedState      state_q;
  FDivSqrtSchedReq        op_q, op_d;
  logic [CW-1:0]          cnt_q;
  logic [TW-1:0]          ptr_q, ptr_d;
  logic                   unit_start_q, unit_kill_q, resp_valid_q;
  logic [31:0]            resp_data_q;
  logic [4:0]             resp_fflags_q;

  logic [NUM_THREADS-1:0] elig, grant;
  logic [TW-1:0]          grant_idx;
  logic                   grant_vld;
  logic                   owner_flush;
  logic                   unused_op_bits;

  assign elig = req_valid & ~flush;

  fpu_rr_arbiter #(
    .NUM_THREADS (NUM_THREADS)
  ) u_arb (
    .req_i         (elig),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_vld)
  );

  assign req_ready = (rst_n && state_q == S_IDLE) ? grant : '0;

  always_comb begin
    op_d           = '0;
    op_d.is_divide = req_is_divide[grant_idx];
    op_d.lhs       = req_lhs[grant_idx];
    op_d.rhs       = req_rhs[grant_idx];
    op_d.tag       = FDIVSQRT_MAX_TAG_WIDTH'(req_tag[grant_idx]);
    op_d.thread    = FDIVSQRT_MAX_THREAD_WIDTH'(grant_idx);
    ptr_d          = (grant_idx == TW'(NUM_THREADS-1)) ? '0 : grant_idx + TW'(1);
  end

  assign owner_flush = flush[op_q.thread[TW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      cnt_q         <= '0;
      ptr_q         <= '0;
      unit_start_q  <= 1'b0;
      unit_kill_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_fflags_q <= '0;
    end else begin
      unit_start_q <= 1'b0;
      unit_kill_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            op_q         <= op_d;
            ptr_q        <= ptr_d;
            unit_start_q <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          if (owner_flush) begin
            unit_kill_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q   <= CW'(ITER_CYCLES-1);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A flush on the result cycle still wins: the result is discarded.
          if (owner_flush) begin
            unit_kill_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (cnt_q == '0) begin
            resp_data_q   <= unit_result;
            resp_fflags_q <= unit_fflags;
            resp_valid_q  <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (owner_flush || resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unit_start     = unit_start_q;
  assign unit_kill      = unit_kill_q;
  assign unit_is_divide = op_q.is_divide;
  assign unit_lhs       = op_q.lhs;
  assign unit_rhs       = op_q.rhs;
  assign resp_valid     = resp_valid_q;
  assign resp_thread    = op_q.thread[TW-1:0];
  assign resp_tag       = op_q.tag[TAG_WIDTH-1:0];
  assign resp_data      = resp_data_q;
  assign resp_fflags    = resp_fflags_q;

  // Tag and thread are stored at their maximum widths; upper bits stay zero.
  assign unused_op_bits = ^{op_q.tag, op_q.thread};

`ifdef FPU_DIVSQRT_SCHED_STATS_EN
  logic [31:0] stat_busy_q, stat_conf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_busy_q <= '0;
      stat_conf_q <= '0;
    end else begin
      if (state_q != S_IDLE && stat_busy_q != '1) begin
        stat_busy_q <= stat_busy_q + 32'd1;
      end
      if (state_q == S_IDLE && $countones(elig) >= 2 && stat_conf_q != '1) begin
        stat_conf_q <= stat_conf_q + 32'd1;
      end
    end
  end

  assign stat_busy_cycles     = stat_busy_q;
  assign stat_conflict_cycles = stat_conf_q;
`endif

endmodule
`default_nettype wire

// File: doc/fpu_divsqrt_scheduler.md
# fpu_divsqrt_scheduler

Shares one iterative floating-point divide/square-root unit between the hardware threads of the SMT core. It round-robin arbitrates per-thread requests and launches the unit with a one-cycle start pulse. It counts the fixed iteration latency, captures the result and returns it to the writeback side with a valid/ready handshake. A per-thread flush cancels the in-flight operation or the pending response.

## Interface
- NUM_THREADS, 2, number of requesting threads (2..4)
- TAG_WIDTH, 7, width of the opaque destination tag
- ITER_CYCLES, 14, cycles the unit needs after the start cycle (≥2)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_THREADS  per-thread request
- req_ready  out  NUM_THREADS  per-thread accept; at most one bit high
- req_is_divide  in  NUM_THREADS  1 = divide, 0 = sqrt
- req_lhs, req_rhs  in  NUM_THREADS×32  operands (rhs ignored for sqrt)
- req_tag  in  NUM_THREADS×TAG_WIDTH  destination tag
- flush  in  NUM_THREADS  per-thread squash
- unit_start  out  1  one-cycle launch pulse
- unit_kill  out  1  one-cycle abort pulse
- unit_is_divide  out  1  registered op select
- unit_lhs, unit_rhs  out  32  registered operands
- unit_result  in  32  unit result, valid in the final BUSY cycle
- unit_fflags  in  5  unit exception flags, valid with unit_result
- resp_valid  out  1  response available
- resp_ready  in  1  writeback accepts
- resp_thread  out  $clog2(NUM_THREADS)  owning thread
- resp_tag  out  TAG_WIDTH  tag
- resp_data  out  32  result
- resp_fflags  out  5  flags

## Operation
- States: IDLE, START, BUSY, RESP. Reset → IDLE.
- All outputs reset to 0. The round-robin pointer resets to thread 0.
- IDLE:
  - Grant the first thread at or after the pointer with req_valid=1 and flush=0.
  - req_ready is high only for that thread (combinational from req_valid/flush).
  - On grant, latch op, operands, tag and owner; move the pointer to owner+1 mod NUM_THREADS; go to START.
- START: unit_start=1 for exactly one cycle; load the counter with ITER_CYCLES-1; go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - At 0, register unit_result/unit_fflags into resp_data/resp_fflags and go to RESP.
- RESP:
  - resp_valid=1; resp_thread/resp_tag/resp_data/resp_fflags are stable.
  - On resp_valid && resp_ready, go to IDLE.
- Flush of the owner in START or BUSY: unit_kill=1 next cycle, state → IDLE, no response.
- Flush of the owner in RESP: response dropped, → IDLE. If resp_ready is also high that cycle, the transfer completes and the consumer discards it.
- Flush of a non-owner: no effect on the current operation.
- No new grant is made while not IDLE. A request is held by its thread until it sees req_ready.

## Timing
- Accept in cycle T → unit_start at T+1 → resp_valid first high at T+ITER_CYCLES+2.
- Back-to-back throughput: one operation per ITER_CYCLES+3 cycles when resp_ready is held high.
- unit_start and unit_kill are never high in the same cycle.
- Reset asserted mid-operation: immediate IDLE, all outputs 0, no kill pulse. The unit is reset by the same rst_n.

## Configuration
- FPU_DIVSQRT_SCHED_STATS_EN defined: adds outputs stat_busy_cycles (32), counting cycles not in IDLE, and stat_conflict_cycles (32), counting IDLE cycles with ≥2 eligible requesters. Both are saturating and reset to 0.
- Undefined: the ports and counters are absent.

## Structure
- Shared FPU package holds:
  - the state enum FDivSqrtSchedState;
  - the struct FDivSqrtSchedReq (is_divide, lhs, rhs, tag, thread);
  - the constant FDIVSQRT_ITER_CYCLES, used as the parameter default.
- One sub-module: fpu_rr_arbiter, a NUM_THREADS round-robin grant with a pointer input and a one-hot grant output.

## Test plan
- Single divide, thread 0, tag 5, ITER_CYCLES=14: accept at T → unit_start at T+1, resp_valid at T+16 with resp_thread=0, resp_tag=5, data = unit model result.
- Both threads request continuously, pointer=0: grants alternate 0,1,0,1. Each response carries the correct thread and tag.
- resp_ready held low 10 cycles in RESP: outputs stable and no new grant; the next grant comes the cycle after the handshake.
- Flush owner at BUSY counter=7: unit_kill one cycle later, state IDLE, resp_valid never rises. Another pending thread is granted next.
- Flush the requesting thread in the same cycle as req_valid: req_ready=0 and no start. Flush of a non-owner mid-BUSY: response still delivered.
- rst_n low during BUSY: all outputs 0 immediately. After release, a new request completes with the nominal latency.
